// File: rtl/int_pkg.sv
// Shared definitions for the interrupt sequencer: FSM state codes, default vectors and a
// highest-set-bit priority encoder.
package int_pkg;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StHandler = 2'd1;
  localparam logic [1:0] StReturn  = 2'd2;

  localparam logic [31:0] VecBaseDflt  = 32'h0000_1000;
  localparam logic [31:0] EcallVecDflt = 32'h0000_0800;

  // Index of the highest set bit; 0 when the vector is empty.
  function automatic logic [4:0] prio_idx(input logic [31:0] vec);
    prio_idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) prio_idx = 5'(i);
    end
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Combinational priority encoder: highest-index set request wins.
module int_prio_enc
  import int_pkg::*;
#(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  output logic            any,
  output logic [IdxW-1:0] idx
);

  assign any = |req;
  assign idx = IdxW'(prio_idx(32'(req)));

endmodule

// File: rtl/int_ctrl.sv
// Interrupt/exception sequencer: IRQ edge latching, priority arbitration, EPC/IE handling and
// one-cycle PC redirects. Define INT_NESTING_EN for preemptive nesting with an EPC/level stack.
module int_ctrl
  import int_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      N_IRQ     = 3,
  parameter logic [WIDTH-1:0] VEC_BASE  = WIDTH'(VecBaseDflt),
  parameter logic [WIDTH-1:0] ECALL_VEC = WIDTH'(EcallVecDflt)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             cmt_valid,
  input  logic [WIDTH-1:0] cmt_pc,
  input  logic [WIDTH-1:0] cmt_next_pc,
  input  logic             cmt_ecall,
  input  logic             cmt_uret,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] epc,
  output logic             ie,
  output logic [N_IRQ-1:0] irq_ack
);

  localparam int unsigned IdxW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [1:0]       state_q, state_d;
  logic [N_IRQ-1:0] irq_q, pending_q, pending_d, irq_ack_q, ack_d, pend_oh;
  logic             redirect_q, redirect_d, ie_q, ie_d, pend_any;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d, epc_q, epc_d, vec_pc;
  logic [IdxW-1:0]  pend_idx;

`ifdef INT_NESTING_EN
  localparam int unsigned LvlW = $clog2(N_IRQ + 1);
  logic [LvlW-1:0]  lvl_q, lvl_d;
  logic [LvlW-1:0]  sp_q, sp_d, sp_m1;
  logic [WIDTH-1:0] epc_stk_q [N_IRQ];
  logic [WIDTH-1:0] epc_stk_d [N_IRQ];
  logic [LvlW-1:0]  lvl_stk_q [N_IRQ];
  logic [LvlW-1:0]  lvl_stk_d [N_IRQ];
  assign sp_m1 = sp_q - LvlW'(1);
`endif

  int_prio_enc #(.N(N_IRQ), .IdxW(IdxW)) u_prio (
    .req (pending_q),
    .any (pend_any),
    .idx (pend_idx)
  );

  assign vec_pc  = VEC_BASE + (WIDTH'(pend_idx) << 2);
  assign pend_oh = N_IRQ'(1) << pend_idx;

  always_comb begin
    state_d       = state_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    epc_d         = epc_q;
    ie_d          = ie_q;
    ack_d         = '0;
`ifdef INT_NESTING_EN
    lvl_d     = lvl_q;
    sp_d      = sp_q;
    epc_stk_d = epc_stk_q;
    lvl_stk_d = lvl_stk_q;
`endif
    case (state_q)
      StIdle: begin
        if (cmt_valid) begin
          if (cmt_ecall) begin
            redirect_d    = 1'b1;
            redirect_pc_d = ECALL_VEC;
            epc_d         = cmt_pc + WIDTH'(4);
            ie_d          = 1'b0;
            state_d       = StHandler;
`ifdef INT_NESTING_EN
            lvl_d = LvlW'(N_IRQ);  // ecall handler is never preempted
`endif
          end else if (ie_q && pend_any) begin
            redirect_d    = 1'b1;
            redirect_pc_d = vec_pc;
            epc_d         = cmt_next_pc;
            ack_d         = pend_oh;
            ie_d          = 1'b0;
            state_d       = StHandler;
`ifdef INT_NESTING_EN
            lvl_d = LvlW'(pend_idx);
`endif
          end
        end
      end
      StHandler: begin
        if (cmt_valid) begin
          if (cmt_uret) begin
            redirect_d    = 1'b1;
            redirect_pc_d = epc_q;
`ifdef INT_NESTING_EN
            if (sp_q == '0) begin
              ie_d    = 1'b1;
              state_d = StReturn;
            end else begin
              epc_d = epc_stk_q[sp_m1];
              lvl_d = lvl_stk_q[sp_m1];
              sp_d  = sp_m1;
            end
`else
            ie_d    = 1'b1;
            state_d = StReturn;
`endif
          end
`ifdef INT_NESTING_EN
          else if (pend_any && (LvlW'(pend_idx) > lvl_q)) begin
            epc_stk_d[sp_q] = epc_q;
            lvl_stk_d[sp_q] = lvl_q;
            sp_d            = sp_q + LvlW'(1);
            redirect_d      = 1'b1;
            redirect_pc_d   = vec_pc;
            epc_d           = cmt_next_pc;
            ack_d           = pend_oh;
            lvl_d           = LvlW'(pend_idx);
          end
`endif
        end
      end
      StReturn: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // A fresh edge on the bit being accepted keeps it pending.
    pending_d = (pending_q & ~ack_d) | (irq_in & ~irq_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      irq_q         <= '0;
      pending_q     <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      epc_q         <= '0;
      ie_q          <= 1'b1;
      irq_ack_q     <= '0;
`ifdef INT_NESTING_EN
      lvl_q <= '0;
      sp_q  <= '0;
      for (int i = 0; i < N_IRQ; i++) begin
        epc_stk_q[i] <= '0;
        lvl_stk_q[i] <= '0;
      end
`endif
    end else begin
      state_q       <= state_d;
      irq_q         <= irq_in;
      pending_q     <= pending_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      epc_q         <= epc_d;
      ie_q          <= ie_d;
      irq_ack_q     <= ack_d;
`ifdef INT_NESTING_EN
      lvl_q     <= lvl_d;
      sp_q      <= sp_d;
      epc_stk_q <= epc_stk_d;
      lvl_stk_q <= lvl_stk_d;
`endif
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign epc         = epc_q;
  assign ie          = ie_q;
  assign irq_ack     = irq_ack_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based behavioural model.
module tb_int_ctrl;

  localparam int N_IRQ = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  irq_in = '0;
  logic        cmt_valid = 1'b0, cmt_ecall = 1'b0, cmt_uret = 1'b0;
  logic [31:0] cmt_pc = '0, cmt_next_pc = '0;
  logic        redirect, ie;
  logic [31:0] redirect_pc, epc;
  logic [2:0]  irq_ack;

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model: mode 0 idle, 1 in handler, 2 returning.
  int          m_mode, m_lvl;
  logic        m_redirect, m_ie;
  logic [31:0] m_rpc, m_epc;
  logic [2:0]  m_ack, m_pend, m_prev, m_clr;
  logic [31:0] s_epc[$];
  int          s_lvl[$];

  int_ctrl #(.WIDTH(32), .N_IRQ(N_IRQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .cmt_valid   (cmt_valid),
    .cmt_pc      (cmt_pc),
    .cmt_next_pc (cmt_next_pc),
    .cmt_ecall   (cmt_ecall),
    .cmt_uret    (cmt_uret),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .epc         (epc),
    .ie          (ie),
    .irq_ack     (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic take_irq(input int k);
    m_redirect = 1'b1;
    m_rpc      = 32'h1000 + 32'(4 * k);
    m_epc      = cmt_next_pc;
    m_ack      = 3'(1 << k);
    m_clr      = m_ack;
    m_ie       = 1'b0;
    m_mode     = 1;
    m_lvl      = k;
  endtask

  task automatic model_step();
    int k;
    m_redirect = 1'b0;
    m_ack      = '0;
    m_clr      = '0;
    if (rst) begin
      m_mode = 0; m_lvl = 0; m_rpc = '0; m_epc = '0; m_ie = 1'b1;
      m_pend = '0; m_prev = '0;
      s_epc.delete(); s_lvl.delete();
    end else begin
      k = -1;
      for (int i = 0; i < N_IRQ; i++) if (m_pend[i]) k = i;
      if (m_mode == 0) begin
        if (cmt_valid) begin
          if (cmt_ecall) begin
            m_redirect = 1'b1; m_rpc = 32'h800; m_epc = cmt_pc + 32'd4;
            m_ie = 1'b0; m_mode = 1; m_lvl = N_IRQ;
          end else if (m_ie && k >= 0) begin
            take_irq(k);
          end
        end
      end else if (m_mode == 1) begin
        if (cmt_valid && cmt_uret) begin
          m_redirect = 1'b1;
          m_rpc      = m_epc;
          if (s_epc.size() == 0) begin
            m_ie = 1'b1; m_mode = 2;
          end else begin
            m_epc = s_epc.pop_back();
            m_lvl = s_lvl.pop_back();
          end
        end
`ifdef INT_NESTING_EN
        else if (cmt_valid && k > m_lvl) begin
          chk("stack_not_full", 32'(s_epc.size() < N_IRQ), 32'd1);
          s_epc.push_back(m_epc);
          s_lvl.push_back(m_lvl);
          take_irq(k);
        end
`endif
      end else begin
        m_mode = 0;
      end
      m_pend = (m_pend & ~m_clr) | (irq_in & ~m_prev);
      m_prev = irq_in;
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, return at the falling edge.
  task automatic cyc(input logic r, input logic [2:0] irq, input logic cv, input logic [31:0] pc,
                     input logic [31:0] npc, input logic ec, input logic ur);
    rst = r; irq_in = irq; cmt_valid = cv; cmt_pc = pc; cmt_next_pc = npc;
    cmt_ecall = ec; cmt_uret = ur;
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("redirect", 32'(redirect), 32'(m_redirect));
      chk("irq_ack", 32'(irq_ack), 32'(m_ack));
      chk("ie", 32'(ie), 32'(m_ie));
      chk("epc", epc, m_epc);
      if (m_redirect) chk("redirect_pc", redirect_pc, m_rpc);
    end
  end

  initial begin
    logic [2:0] irq_r;
    cyc(1, 3'b000, 0, 0, 0, 0, 0);
    cyc(1, 3'b000, 0, 0, 0, 0, 0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_ie", 32'(ie), 32'd1);
    chk("rst_ack", 32'(irq_ack), 32'd0);

    // IRQ1 edge, then a commit with next_pc 0x40
    cyc(0, 3'b010, 0, 0, 0, 0, 0);
    cyc(0, 3'b010, 1, 32'h3c, 32'h40, 0, 0);
    chk("t1_redirect", 32'(redirect), 32'd1);
    chk("t1_rpc", redirect_pc, 32'h1004);
    chk("t1_epc", epc, 32'h40);
    chk("t1_ack", 32'(irq_ack), 32'b010);
    chk("t1_ie", 32'(ie), 32'd0);
    cyc(0, 3'b010, 0, 0, 0, 0, 0);
    chk("t1_pulse", 32'(redirect), 32'd0);
    chk("t1_ack_pulse", 32'(irq_ack), 32'd0);

    cyc(0, 3'b010, 1, 32'h1004, 32'h1008, 0, 1);
    chk("t2_rpc", redirect_pc, 32'h40);
    chk("t2_ie", 32'(ie), 32'd1);
    cyc(0, 3'b010, 0, 0, 0, 0, 0);
    chk("t2_ret", 32'(redirect), 32'd0);

    // ecall and IRQ0 edge in the same commit cycle
    cyc(0, 3'b011, 1, 32'h20, 32'h24, 1, 0);
    chk("t3_rpc", redirect_pc, 32'h800);
    chk("t3_epc", epc, 32'h24);
    chk("t3_ack", 32'(irq_ack), 32'd0);
    cyc(0, 3'b011, 1, 32'h800, 32'h804, 0, 1);
    chk("t3_uret_rpc", redirect_pc, 32'h24);
    cyc(0, 3'b011, 0, 0, 0, 0, 0);
    cyc(0, 3'b011, 1, 32'h24, 32'h100, 0, 0);
    chk("t3_irq0_rpc", redirect_pc, 32'h1000);
    chk("t3_irq0_ack", 32'(irq_ack), 32'b001);
    chk("t3_irq0_epc", epc, 32'h100);
    cyc(0, 3'b011, 1, 32'h1000, 32'h1004, 0, 1);
    cyc(0, 3'b000, 0, 0, 0, 0, 0);

    // simultaneous IRQ0 and IRQ2 edges
    cyc(0, 3'b101, 0, 0, 0, 0, 0);
    cyc(0, 3'b101, 1, 32'h1fc, 32'h200, 0, 0);
    chk("t4_rpc2", redirect_pc, 32'h1008);
    chk("t4_ack2", 32'(irq_ack), 32'b100);
    cyc(0, 3'b101, 1, 32'h1008, 32'h100c, 0, 1);
    cyc(0, 3'b101, 0, 0, 0, 0, 0);
    cyc(0, 3'b101, 1, 32'h200, 32'h300, 0, 0);
    chk("t4_rpc0", redirect_pc, 32'h1000);
    chk("t4_ack0", 32'(irq_ack), 32'b001);
    cyc(0, 3'b000, 1, 32'h1000, 32'h1004, 0, 1);
    cyc(0, 3'b000, 0, 0, 0, 0, 0);

    // edge while nothing commits
    for (int i = 0; i < 5; i++) begin
      cyc(0, 3'b010, 0, 0, 0, 0, 0);
      chk("t5_hold", 32'(redirect), 32'd0);
    end
    cyc(0, 3'b010, 1, 32'h4fc, 32'h500, 0, 0);
    chk("t5_rpc", redirect_pc, 32'h1004);
    chk("t5_epc", epc, 32'h500);

    // reset while in the handler
    cyc(1, 3'b000, 0, 0, 0, 0, 0);
    chk("t6_ie", 32'(ie), 32'd1);
    chk("t6_epc", epc, 32'd0);
    chk("t6_redirect", 32'(redirect), 32'd0);
    cyc(0, 3'b000, 1, 32'h10, 32'h14, 0, 0);
    chk("t6_nopend", 32'(redirect), 32'd0);

    // epc wraps modulo 2^32
    cyc(0, 3'b000, 1, 32'hffff_fffc, 32'h0, 1, 0);
    chk("wrap_epc", epc, 32'h0);
    cyc(0, 3'b000, 1, 32'h800, 32'h804, 0, 1);
    cyc(0, 3'b000, 0, 0, 0, 0, 0);

`ifdef INT_NESTING_EN
    cyc(0, 3'b001, 0, 0, 0, 0, 0);
    cyc(0, 3'b001, 1, 32'hc, 32'h10, 0, 0);
    cyc(0, 3'b101, 0, 0, 0, 0, 0);
    cyc(0, 3'b101, 1, 32'h1000, 32'h20, 0, 0);
    chk("nest_rpc", redirect_pc, 32'h1008);
    cyc(0, 3'b101, 1, 32'h1008, 32'h100c, 0, 1);
    chk("nest_ret1", redirect_pc, 32'h20);
    chk("nest_ie0", 32'(ie), 32'd0);
    cyc(0, 3'b101, 1, 32'h20, 32'h24, 0, 1);
    chk("nest_ret2", redirect_pc, 32'h10);
    chk("nest_ie1", 32'(ie), 32'd1);
    cyc(0, 3'b000, 0, 0, 0, 0, 0);
`endif

    irq_r = '0;
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < N_IRQ; b++) if ($urandom_range(0, 5) == 0) irq_r[b] = ~irq_r[b];
      cyc(($urandom_range(0, 299) == 0),
          irq_r,
          (m_mode != 2) && ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 15) == 0) ? 32'hffff_fffc : ($urandom() & 32'hffff_fffc),
          $urandom() & 32'hffff_fffc,
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
